// File: rtl/stopwatch_up_mmss.sv
// MM:SS elapsed-time counter (00:00..99:59) in BCD, advanced once per one-second tick.
// A four-state control FSM sequences the start/stop/clear pulses.
module stopwatch_up_mmss #(
  parameter bit ROLLOVER = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       max_L
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t     state_r;
  logic [3:0] sec_ones_r, sec_tens_r, min_ones_r, min_tens_r;
  logic       running_r;
  logic [3:0] sec_ones_s, sec_tens_s, min_ones_s, min_tens_s;
  logic       at_max_s, next_at_max_s;

  // Next-digit value for one increment; every carry resolves within the same edge.
  always_comb begin
    sec_ones_s = sec_ones_r;
    sec_tens_s = sec_tens_r;
    min_ones_s = min_ones_r;
    min_tens_s = min_tens_r;
    if (sec_ones_r == 4'd9) begin
      sec_ones_s = 4'd0;
      if (sec_tens_r == 4'd5) begin
        sec_tens_s = 4'd0;
        if (min_ones_r == 4'd9) begin
          min_ones_s = 4'd0;
          if (min_tens_r == 4'd9) begin
            min_tens_s = 4'd0;
          end else begin
            min_tens_s = min_tens_r + 4'd1;
          end
        end else begin
          min_ones_s = min_ones_r + 4'd1;
        end
      end else begin
        sec_tens_s = sec_tens_r + 4'd1;
      end
    end else begin
      sec_ones_s = sec_ones_r + 4'd1;
    end
  end

  assign at_max_s      = (min_tens_r == 4'd9) && (min_ones_r == 4'd9) &&
                         (sec_tens_r == 4'd5) && (sec_ones_r == 4'd9);
  assign next_at_max_s = (min_tens_s == 4'd9) && (min_ones_s == 4'd9) &&
                         (sec_tens_s == 4'd5) && (sec_ones_s == 4'd9);

  // Control FSM with digit registers and registered running flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      running_r  <= 1'b0;
      sec_ones_r <= 4'd0;
      sec_tens_r <= 4'd0;
      min_ones_r <= 4'd0;
      min_tens_r <= 4'd0;
    end else if (clear) begin
      state_r    <= ST_IDLE;
      running_r  <= 1'b0;
      sec_ones_r <= 4'd0;
      sec_tens_r <= 4'd0;
      min_ones_r <= 4'd0;
      min_tens_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_stop) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (tick && !ROLLOVER && at_max_s) begin
            // Saturated value with no wrap allowed: never increment past it.
            state_r   <= ST_DONE;
            running_r <= 1'b0;
          end else if (tick && !ROLLOVER && next_at_max_s) begin
            // Landing on 99:59 ends the count even if a stop arrives together.
            sec_ones_r <= sec_ones_s;
            sec_tens_r <= sec_tens_s;
            min_ones_r <= min_ones_s;
            min_tens_r <= min_tens_s;
            state_r    <= ST_DONE;
            running_r  <= 1'b0;
          end else begin
            if (tick) begin
              sec_ones_r <= sec_ones_s;
              sec_tens_r <= sec_tens_s;
              min_ones_r <= min_ones_s;
              min_tens_r <= min_tens_s;
            end
            if (start_stop) begin
              state_r   <= ST_PAUSE;
              running_r <= 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end
        end
        ST_DONE: begin
          running_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          running_r  <= 1'b0;
          sec_ones_r <= 4'd0;
          sec_tens_r <= 4'd0;
          min_ones_r <= 4'd0;
          min_tens_r <= 4'd0;
        end
      endcase
    end
  end

  assign sec_ones = sec_ones_r;
  assign sec_tens = sec_tens_r;
  assign min_ones = min_ones_r;
  assign min_tens = min_tens_r;
  assign running  = running_r;
  assign max_L    = ~at_max_s;

endmodule

// File: tb/tb_stopwatch_up_mmss.sv
// Directed bench for stopwatch_up_mmss: one instance saturating, one wrapping,
// both driven by the same stimulus.
module tb_stopwatch_up_mmss;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;

  logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
  logic       running0, running1, max_l0, max_l1;
  logic [15:0] digits0, digits1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stopwatch_up_mmss #(.ROLLOVER(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
    .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
    .running(running0), .max_L(max_l0)
  );

  stopwatch_up_mmss #(.ROLLOVER(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
    .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
    .running(running1), .max_L(max_l1)
  );

  assign digits0 = {mt0, mo0, st0, so0};
  assign digits1 = {mt1, mo1, st1, so1};

  task automatic check_value(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns at the next negedge.
  task automatic cycle(input logic ss, input logic tk, input logic cl);
    start_stop = ss;
    tick       = tk;
    clear      = cl;
    @(negedge clk);
    start_stop = 1'b0;
    tick       = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #2;
    check_value("reset_digits", digits0, 16'h0000);
    check_value("reset_running", {15'd0, running0}, 16'h0000);
    check_value("reset_max_L", {15'd0, max_l0}, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    ticks(2);
    check_value("idle_ignores_tick", digits0, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0);
    check_value("start_running", {15'd0, running0}, 16'h0001);
    ticks(3);
    check_value("three_ticks", digits0, 16'h0003);
    check_value("three_ticks_max_L", {15'd0, max_l0}, 16'h0001);

    ticks(2);
    cycle(1'b1, 1'b0, 1'b0);
    check_value("pause_running", {15'd0, running0}, 16'h0000);
    ticks(4);
    check_value("pause_hold", digits0, 16'h0005);
    cycle(1'b1, 1'b0, 1'b0);
    ticks(1);
    check_value("resume_tick", digits0, 16'h0006);
    check_value("resume_running", {15'd0, running0}, 16'h0001);

    ticks(3);
    check_value("at_0009", digits0, 16'h0009);
    cycle(1'b1, 1'b1, 1'b0);
    check_value("run_tick_stop_digits", digits0, 16'h0010);
    check_value("run_tick_stop_paused", {15'd0, running0}, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0);
    check_value("pause_tick_start_digits", digits0, 16'h0010);
    check_value("pause_tick_start_run", {15'd0, running0}, 16'h0001);

    ticks(50);
    check_value("carry_0100", digits0, 16'h0100);
    ticks(539);
    check_value("at_0959", digits0, 16'h0959);
    ticks(1);
    check_value("carry_1000", digits0, 16'h1000);

    cycle(1'b1, 1'b1, 1'b1);
    check_value("clear_all_digits", digits0, 16'h0000);
    check_value("clear_all_running", {15'd0, running0}, 16'h0000);

    cycle(1'b1, 1'b0, 1'b0);
    ticks(5999);
    check_value("sat_digits", digits0, 16'h9959);
    check_value("sat_max_L", {15'd0, max_l0}, 16'h0000);
    check_value("sat_done_running", {15'd0, running0}, 16'h0000);
    check_value("wrap_pre_digits", digits1, 16'h9959);
    check_value("wrap_pre_running", {15'd0, running1}, 16'h0001);
    ticks(1);
    check_value("sat_hold", digits0, 16'h9959);
    check_value("wrap_digits", digits1, 16'h0000);
    check_value("wrap_running", {15'd0, running1}, 16'h0001);
    check_value("wrap_max_L", {15'd0, max_l1}, 16'h0001);
    cycle(1'b1, 1'b0, 1'b0);
    ticks(2);
    check_value("done_ignores_start", digits0, 16'h9959);
    check_value("done_stays_stopped", {15'd0, running0}, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1);
    check_value("done_clear_digits", digits0, 16'h0000);
    check_value("done_clear_max_L", {15'd0, max_l0}, 16'h0001);
    ticks(1);
    check_value("after_clear_idle", digits0, 16'h0000);

    cycle(1'b1, 1'b0, 1'b0);
    ticks(7);
    check_value("pre_reset_count", digits0, 16'h0007);
    #2;
    rst = 1'b0;
    #1;
    check_value("async_reset_digits", digits0, 16'h0000);
    check_value("async_reset_running", {15'd0, running0}, 16'h0000);
    check_value("async_reset_wrap", digits1, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ticks(1);
    check_value("post_reset_idle", digits0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_up_mmss.md
# stopwatch_up_mmss

- Four-digit BCD elapsed-time counter (MM:SS, 00:00 to 99:59) that counts up once per one-second tick.
- It is the up-counting counterpart to the microwave timer's countdown digits and reuses the same digit chaining (ones, tens mod 6, minute ones, minute tens).
- It sits beside the timer in the LVL2 datapath and drives the same seven-segment display path.
- A small control FSM (IDLE/RUN/PAUSE/DONE) sequences start/stop/clear button pulses.

## Interface
Parameters:
- ROLLOVER, 0, 0 = hold at 99:59 and enter DONE; 1 = wrap 99:59 -> 00:00 and keep running

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle pulse, once per second, synchronous to clk
- start_stop  input  1  one-cycle pulse (debounced upstream); toggles run/pause
- clear  input  1  one-cycle pulse; zero digits and return to IDLE
- sec_ones  output  4  BCD 0-9
- sec_tens  output  4  BCD 0-5
- min_ones  output  4  BCD 0-9
- min_tens  output  4  BCD 0-9
- running  output  1  high only in RUN
- max_L  output  1  active-low; low exactly while digits read 99:59

## Operation
- Digits are registered. In normal operation they only ever hold in-range BCD values, and there is no load path.
- One increment is performed on a clk edge where the state is RUN and tick = 1. The increment is a ripple of carries:
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0, only when sec_ones also wraps, carries into min_ones.
  - min_ones 9 -> 0 with the lower wraps carries into min_tens.
  - min_tens 9 -> 0 happens only at 99:59 with ROLLOVER = 1.
- FSM states and transitions (priority: clear > start_stop > tick):
  - IDLE: digits 00:00. start_stop -> RUN. tick ignored.
  - RUN: tick increments. start_stop -> PAUSE. If ROLLOVER = 0 and the increment lands on 99:59 -> DONE on the same edge.
  - PAUSE: digits hold. start_stop -> RUN. tick ignored.
  - DONE: digits hold 99:59. start_stop ignored. Only clear or reset exits.
  - clear in any state -> IDLE with digits 00:00 on the same edge.
- tick and start_stop together in RUN: the increment is applied and the state goes to PAUSE on the same edge.
- tick and start_stop together in IDLE/PAUSE: state goes to RUN and the tick is discarded. The first count occurs on the next tick.
- ROLLOVER = 1: at 99:59 a tick gives 00:00, the state stays RUN, and DONE is unreachable.
- If an illegal state encoding is reached, the FSM returns to IDLE on the next edge.
- max_L is decoded combinationally from the digit registers. running is decoded from the state.

## Timing
- Reset (rst low, asynchronous, takes effect immediately without a clock):
  - all four digits 0
  - state IDLE
  - running 0
  - max_L 1
- Release of rst is sampled on the next rising clk. The block is idle until a start_stop pulse.
- Reset mid-count discards the count with no saved value.
- Latency:
  - The digits reflect an accepted tick one clk edge after it is sampled.
  - running changes on the edge that samples start_stop.
  - max_L follows the digits in the same cycle.
- All digit updates are atomic on a single edge; no intermediate carry values are visible.
- tick asserted for multiple consecutive cycles counts once per cycle. Upstream guarantees single-cycle pulses.

## Test plan
- Reset then start: rst low, release, start_stop pulse, 3 ticks -> digits 00:03, running = 1, max_L = 1.
- Carry chain: run from 00:00 with 60 ticks -> 01:00. Continue to 09:59 plus 1 tick -> 10:00.
- Pause/resume: at 00:05 pulse start_stop, then 4 ticks -> holds 00:05, running = 0. Pulse start_stop and 1 tick -> 00:06.
- Saturation, ROLLOVER = 0: tick to 99:59 -> max_L = 0, state DONE, running = 0. Further ticks and start_stop -> still 99:59. clear -> 00:00, IDLE, max_L = 1.
- Wrap, ROLLOVER = 1: from 99:59 one tick -> 00:00, running = 1, max_L returns to 1.
- Simultaneous events:
  - In RUN at 00:09, tick + start_stop -> 00:10 and PAUSE.
  - In PAUSE, tick + start_stop -> RUN with digits unchanged.
  - clear + tick + start_stop in RUN -> 00:00, IDLE.
  - rst asserted between clock edges mid-count -> outputs zero before the next edge.
